// File: rtl/trap_csr_unit_if.sv
// Commit-stage / CSR-unit bundle: writeback, trap controls, read port and redirect.
interface trap_csr_unit_if;
  logic [31:0] csr_wb;
  logic [11:0] csr_wb_addr;
  logic        csr_we;
  logic [31:0] pc_exc;
  logic [31:0] cause;
  logic        exception_pending;
  logic        mret;
  logic        sret;
  logic        uret;
  logic        retire;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_illegal;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        mie_global;

  // Pipeline side: drives commit information and the read address.
  modport master (
    output csr_wb, csr_wb_addr, csr_we, pc_exc, cause, exception_pending,
           mret, sret, uret, retire, csr_rd_addr,
    input  csr_rd_data, csr_rd_illegal, redirect, redirect_pc, flush, mie_global
  );

  // CSR unit side.
  modport slave (
    input  csr_wb, csr_wb_addr, csr_we, pc_exc, cause, exception_pending,
           mret, sret, uret, retire, csr_rd_addr,
    output csr_rd_data, csr_rd_illegal, redirect, redirect_pc, flush, mie_global
  );
endinterface

// File: rtl/trap_csr_unit.sv
// Machine-mode CSR file and trap sequencer with a one-cycle redirect/flush pulse.
module trap_csr_unit #(
  parameter int          HART_ID     = 0,
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
  input logic           clk,
  input logic           nrst,
  trap_csr_unit_if.slave bus
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_REDIRECT = 1'b1;

  logic [0:0]  state_q, state_d;
  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;
  logic        redirect_q, redirect_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  logic [31:0] rd_data_s;
  logic        rd_illegal_s;
  logic [31:0] mstatus_s;
  logic [31:0] trap_target_s;
  logic        unused_s;

  // sret/uret are accepted on the bus but have no architectural effect.
  assign unused_s = bus.sret | bus.uret;

  // MPP is hard-wired to machine mode; all other mstatus bits read zero.
  assign mstatus_s = {19'd0, 2'b11, 3'd0, mpie_q, 3'd0, mie_q, 3'd0};

  // Trap vector: vectored mode only offsets asynchronous (interrupt) causes.
  always_comb begin
    trap_target_s = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[1:0] == 2'b01 && bus.cause[31]) begin
      trap_target_s = {mtvec_q[31:2], 2'b00} + {bus.cause[29:0], 2'b00};
    end else begin
      trap_target_s = {mtvec_q[31:2], 2'b00};
    end
  end

  // Combinational read port returning current (pre-write) register values.
  always_comb begin
    rd_data_s    = 32'd0;
    rd_illegal_s = 1'b0;
    case (bus.csr_rd_addr)
      12'h300: rd_data_s = mstatus_s;
      12'h305: rd_data_s = mtvec_q;
      12'h340: rd_data_s = mscratch_q;
      12'h341: rd_data_s = mepc_q;
      12'h342: rd_data_s = mcause_q;
      12'hB00: rd_data_s = mcycle_q[31:0];
      12'hB80: rd_data_s = mcycle_q[63:32];
      12'hB02: rd_data_s = minstret_q[31:0];
      12'hB82: rd_data_s = minstret_q[63:32];
      12'hF14: rd_data_s = 32'(HART_ID);
      default: begin
        rd_data_s    = 32'd0;
        rd_illegal_s = 1'b1;
      end
    endcase
  end

  // Next-state: counters, then trap > mret > CSR write while idle.
  always_comb begin
    state_d       = ST_IDLE;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mscratch_d    = mscratch_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    mcycle_d      = mcycle_q + 64'd1;
    if (bus.retire && state_q == ST_IDLE && !bus.exception_pending) begin
      minstret_d = minstret_q + 64'd1;
    end else begin
      minstret_d = minstret_q;
    end

    if (state_q == ST_IDLE) begin
      if (bus.exception_pending) begin
        mepc_d        = {bus.pc_exc[31:2], 2'b00};
        mcause_d      = bus.cause;
        mpie_d        = mie_q;
        mie_d         = 1'b0;
        redirect_d    = 1'b1;
        redirect_pc_d = trap_target_s;
        state_d       = ST_REDIRECT;
      end else if (bus.mret) begin
        mie_d         = mpie_q;
        mpie_d        = 1'b1;
        redirect_d    = 1'b1;
        redirect_pc_d = mepc_q;
        state_d       = ST_REDIRECT;
      end else if (bus.csr_we) begin
        case (bus.csr_wb_addr)
          12'h300: begin
            mie_d  = bus.csr_wb[3];
            mpie_d = bus.csr_wb[7];
          end
          // Reserved modes 1x collapse to direct.
          12'h305: mtvec_d = {bus.csr_wb[31:2], bus.csr_wb[1] ? 2'b00 : bus.csr_wb[1:0]};
          12'h340: mscratch_d = bus.csr_wb;
          12'h341: mepc_d     = {bus.csr_wb[31:2], 2'b00};
          12'h342: mcause_d   = bus.csr_wb;
          12'hB00: mcycle_d   = {mcycle_q[63:32], bus.csr_wb};
          12'hB80: mcycle_d   = {bus.csr_wb, mcycle_q[31:0]};
          12'hB02: minstret_d = {minstret_q[63:32], bus.csr_wb};
          12'hB82: minstret_d = {bus.csr_wb, minstret_q[31:0]};
          default: mscratch_d = mscratch_q;
        endcase
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d    = ST_IDLE;
      redirect_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      mie_q         <= 1'b0;
      mpie_q        <= 1'b0;
      mtvec_q       <= RESET_MTVEC;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mscratch_q    <= 32'd0;
      mcycle_q      <= 64'd0;
      minstret_q    <= 64'd0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      mie_q         <= mie_d;
      mpie_q        <= mpie_d;
      mtvec_q       <= mtvec_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mscratch_q    <= mscratch_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign bus.csr_rd_data    = rd_data_s;
  assign bus.csr_rd_illegal = rd_illegal_s;
  assign bus.redirect       = redirect_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.flush          = redirect_q;
  assign bus.mie_global     = mie_q;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed table-driven bench for trap_csr_unit plus counter and reset sequences.
module tb_trap_csr_unit;

  logic clk;
  logic nrst;
  int   n_cmp;
  int   n_fail;

  trap_csr_unit_if bus ();

  trap_csr_unit #(.HART_ID(0), .RESET_MTVEC(32'h0000_0100)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [11:0] wb_addr;
    logic [31:0] wb;
    logic        exc;
    logic [31:0] pc;
    logic [31:0] cause;
    logic        mret;
    logic        xret;
    logic [11:0] rd_addr;
    logic [31:0] exp_data;
    logic        exp_ill;
    logic        exp_redir;
    logic [31:0] exp_pc;
    logic        exp_mie;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csr_we = 1'b0; bus.csr_wb_addr = 12'h000; bus.csr_wb = 32'd0;
    bus.exception_pending = 1'b0; bus.pc_exc = 32'd0; bus.cause = 32'd0;
    bus.mret = 1'b0; bus.sret = 1'b0; bus.uret = 1'b0; bus.retire = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [31:0] d);
    bus.csr_we = 1'b1; bus.csr_wb_addr = a; bus.csr_wb = d;
    tick();
    bus.csr_we = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    //          we    waddr    wdata           exc   pc             cause          mret  xret  rdaddr   data           ill   redir pc             mie
    vecs[0]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h305, 32'h0000_0100, 1'b0, 1'b0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h7C0, 32'h0,         1'b1, 1'b0, 32'h0,         1'b0};
    vecs[2]  = '{1'b1, 12'h300, 32'h8,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1808, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[3]  = '{1'b0, 12'h000, 32'h0,          1'b1, 32'h0000_2002, 32'h2,         1'b0, 1'b0, 12'h341, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_0100, 1'b0};
    vecs[4]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h342, 32'h2,         1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[5]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[6]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 12'h300, 32'h0000_1888, 1'b0, 1'b1, 32'h0000_2000, 1'b1};
    vecs[7]  = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1888, 1'b0, 1'b0, 32'h0000_2000, 1'b1};
    vecs[8]  = '{1'b1, 12'h305, 32'h0000_0201,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h305, 32'h0000_0201, 1'b0, 1'b0, 32'h0000_2000, 1'b1};
    vecs[9]  = '{1'b0, 12'h000, 32'h0,          1'b1, 32'h0000_3000, 32'h8000_0007, 1'b0, 1'b0, 12'h342, 32'h8000_0007, 1'b0, 1'b1, 32'h0000_021C, 1'b0};
    vecs[10] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 1'b0, 32'h0000_021C, 1'b0};
    vecs[11] = '{1'b0, 12'h000, 32'h0,          1'b1, 32'h0000_3006, 32'h3,         1'b0, 1'b0, 12'h341, 32'h0000_3004, 1'b0, 1'b1, 32'h0000_0200, 1'b0};
    vecs[12] = '{1'b1, 12'h340, 32'h0000_1111,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h340, 32'h0,         1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[13] = '{1'b1, 12'h340, 32'h0000_DEAD,  1'b1, 32'h0000_4000, 32'h5,         1'b1, 1'b0, 12'h340, 32'h0,         1'b0, 1'b1, 32'h0000_0200, 1'b0};
    vecs[14] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h342, 32'h5,         1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[15] = '{1'b1, 12'h340, 32'h0000_DEAD,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h340, 32'h0000_DEAD, 1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[16] = '{1'b1, 12'h305, 32'h0000_0003,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h305, 32'h0,         1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[17] = '{1'b1, 12'hF14, 32'h0000_0055,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'hF14, 32'h0,         1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[18] = '{1'b1, 12'h341, 32'h0000_1237,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h341, 32'h0000_1234, 1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[19] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b1, 12'h300, 32'h0000_1800, 1'b0, 1'b0, 32'h0000_0200, 1'b0};
    vecs[20] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 1'b1, 32'h0000_1234, 1'b0};
    vecs[21] = '{1'b1, 12'h300, 32'hFFFF_FFFF,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 1'b0, 32'h0000_1234, 1'b0};
    vecs[22] = '{1'b1, 12'h300, 32'hFFFF_FFFF,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1888, 1'b0, 1'b0, 32'h0000_1234, 1'b1};
    vecs[23] = '{1'b1, 12'h7C0, 32'h0000_0001,  1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h7C0, 32'h0,         1'b1, 1'b0, 32'h0000_1234, 1'b1};
    vecs[24] = '{1'b0, 12'h000, 32'h0,          1'b1, 32'h0000_0010, 32'h8000_0003, 1'b0, 1'b0, 12'h305, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0};
    vecs[25] = '{1'b0, 12'h000, 32'h0,          1'b0, 32'h0,         32'h0,         1'b0, 1'b0, 12'h300, 32'h0000_1880, 1'b0, 1'b0, 32'h0,         1'b0};

    idle_inputs();
    bus.csr_rd_addr = 12'h305;
    nrst = 1'b0;
    #12;
    check("reset_mtvec", bus.csr_rd_data, 32'h0000_0100);
    check("reset_redirect", {31'd0, bus.redirect}, 32'd0);
    check("reset_mie", {31'd0, bus.mie_global}, 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    tick();

    // Table: inputs applied for one edge, outputs sampled just after it.
    for (int i = 0; i < 26; i++) begin
      bus.csr_we = vecs[i].we; bus.csr_wb_addr = vecs[i].wb_addr; bus.csr_wb = vecs[i].wb;
      bus.exception_pending = vecs[i].exc; bus.pc_exc = vecs[i].pc; bus.cause = vecs[i].cause;
      bus.mret = vecs[i].mret; bus.sret = vecs[i].xret; bus.uret = vecs[i].xret;
      bus.retire = 1'b0; bus.csr_rd_addr = vecs[i].rd_addr;
      tick();
      check($sformatf("v%0d_rd_data", i), bus.csr_rd_data, vecs[i].exp_data);
      check($sformatf("v%0d_rd_illegal", i), {31'd0, bus.csr_rd_illegal}, {31'd0, vecs[i].exp_ill});
      check($sformatf("v%0d_redirect", i), {31'd0, bus.redirect}, {31'd0, vecs[i].exp_redir});
      check($sformatf("v%0d_flush", i), {31'd0, bus.flush}, {31'd0, vecs[i].exp_redir});
      check($sformatf("v%0d_redirect_pc", i), bus.redirect_pc, vecs[i].exp_pc);
      check($sformatf("v%0d_mie_global", i), {31'd0, bus.mie_global}, {31'd0, vecs[i].exp_mie});
    end
    idle_inputs();

    // mcycle carry across halves after writes override the increment.
    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0);
    bus.csr_rd_addr = 12'hB80;
    tick();
    check("mcycleh_carry", bus.csr_rd_data, 32'h1);
    bus.csr_rd_addr = 12'hB00;
    #1;
    check("mcycle_wrapped_low", bus.csr_rd_data, 32'h0);

    // minstret counts idle retires only.
    csr_write(12'hB02, 32'h0);
    csr_write(12'hB82, 32'h0);
    bus.retire = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    bus.retire = 1'b0;
    bus.csr_rd_addr = 12'hB02;
    #1;
    check("minstret_10", bus.csr_rd_data, 32'd10);
    bus.retire = 1'b1; bus.exception_pending = 1'b1;
    tick();
    bus.exception_pending = 1'b0;
    tick();
    bus.retire = 1'b0;
    #1;
    check("minstret_trap_redirect_hold", bus.csr_rd_data, 32'd10);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    #1;
    check("minstret_11", bus.csr_rd_data, 32'd11);

    // 64-bit wrap to zero.
    csr_write(12'hB02, 32'hFFFF_FFFF);
    csr_write(12'hB82, 32'hFFFF_FFFF);
    bus.retire = 1'b1;
    tick();
    bus.retire = 1'b0;
    bus.csr_rd_addr = 12'hB02;
    #1;
    check("minstret_wrap_lo", bus.csr_rd_data, 32'h0);
    bus.csr_rd_addr = 12'hB82;
    #1;
    check("minstret_wrap_hi", bus.csr_rd_data, 32'h0);

    // Reset asserted during the redirect cycle.
    bus.exception_pending = 1'b1; bus.pc_exc = 32'h0000_0500; bus.cause = 32'h1;
    tick();
    bus.exception_pending = 1'b0;
    check("pre_reset_redirect", {31'd0, bus.redirect}, 32'd1);
    nrst = 1'b0;
    #1;
    check("midreset_redirect", {31'd0, bus.redirect}, 32'd0);
    check("midreset_flush", {31'd0, bus.flush}, 32'd0);
    bus.csr_rd_addr = 12'h341;
    #1;
    check("midreset_mepc", bus.csr_rd_data, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    bus.csr_rd_addr = 12'h300;
    tick();
    check("postreset_redirect", {31'd0, bus.redirect}, 32'd0);
    check("postreset_mstatus", bus.csr_rd_data, 32'h0000_1800);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_csr_unit.md
Name: trap_csr_unit

Overview:
- Machine-mode CSR file and trap sequencer; sinks the commit-stage writeback/exception interface.
- Applies committed CSR writes and traps on exception_pending, restoring state on mret.
- Drives a registered one-cycle front-end redirect and pipeline flush.
- Gives the execute stage a combinational CSR read port.

Parameters:
- HART_ID, 0, value returned for mhartid (0xF14).
- RESET_MTVEC, 32'h0000_0100, reset value of mtvec.

Ports:
- clk  in  1  clock
- nrst  in  1  async active-low reset
- csr_wb  in  32  committed CSR write data
- csr_wb_addr  in  12  committed CSR address
- csr_we  in  1  committed CSR write enable
- pc_exc  in  32  PC of the committing instruction
- cause  in  32  trap cause; bit31 = interrupt
- exception_pending  in  1  committing instruction traps
- mret  in  1  committing MRET
- sret  in  1  committing SRET (unsupported, ignored)
- uret  in  1  committing URET (unsupported, ignored)
- retire  in  1  one instruction retired this cycle
- csr_rd_addr  in  12  read address
- csr_rd_data  out  32  read data
- csr_rd_illegal  out  1  read address not implemented
- redirect  out  1  front-end redirect pulse
- redirect_pc  out  32  redirect target
- flush  out  1  pipeline flush; equals redirect
- mie_global  out  1  mstatus.MIE

Behaviour:
- Clock and reset: one clock, clk; reset nrst is asynchronous, active-low.
- Reset values:
  - mstatus: MIE=0, MPIE=0, MPP=2'b11.
  - mtvec=RESET_MTVEC; mepc, mcause, mscratch, mcycle, minstret = 0.
  - redirect=0, redirect_pc=0, state=IDLE.
- CSRs implemented:
  - mstatus 0x300 (MIE bit3, MPIE bit7, MPP[12:11] read-only 11, other bits read 0).
  - mtvec 0x305 (mode[1:0]: 00 direct, 01 vectored, 1x written as 00).
  - mscratch 0x340; mepc 0x341 (bits[1:0] forced 0); mcause 0x342.
  - mcycle 0xB00 / mcycleh 0xB80; minstret 0xB02 / minstreth 0xB82; mhartid 0xF14 (read-only).
- Read port: combinational. Unimplemented address -> data 0, csr_rd_illegal=1. Reads return pre-write (current register) values.
- FSM states: IDLE, REDIRECT.
- In IDLE, priority exception_pending > mret > csr_we. Only the winner takes effect; retire still counts.
- Trap (exception_pending=1), next edge:
  - mepc<=pc_exc&~3; mcause<=cause; MPIE<=MIE; MIE<=0.
  - Target = mtvec base (mtvec&~3). If mode=01 and cause[31]=1: base + (cause[30:0]<<2), mod 2^32.
  - redirect<=1, redirect_pc<=target, state<=REDIRECT.
- mret, next edge: MIE<=MPIE; MPIE<=1; redirect_pc<=mepc; redirect<=1; state<=REDIRECT.
- csr_we alone: write the addressed implemented writable CSR next edge. Writes to read-only or unimplemented addresses are dropped silently.
- REDIRECT: lasts exactly one cycle, redirect=1, then back to IDLE with redirect=0. All exception, mret and csr_we inputs are ignored here (pipeline being flushed). Counters keep running.
- Counters: 64-bit.
  - mcycle +1 every cycle.
  - minstret +1 when retire=1 and state=IDLE and exception_pending=0.
  - Wrap 2^64-1 -> 0.
  - A CSR write to either half that edge overrides the increment for the whole 64-bit counter: the written half takes the new value, the other half holds.
- sret/uret: no state change, no redirect.
- Reset mid-REDIRECT: immediate return to IDLE, redirect=0.

Test Plan:
- Reset release, csr_rd_addr=0x305 -> csr_rd_data=0x100, redirect=0; 0x7C0 -> illegal=1, data=0.
- Write mstatus=0x8, then exception_pending with pc_exc=0x2002, cause=2 -> next cycle redirect=1, redirect_pc=0x100; mepc=0x2000, mcause=2, MIE=0, MPIE=1; following cycle redirect=0.
- mtvec=0x201, cause=0x8000_0007 -> redirect_pc=0x21C; with cause=3 (sync) -> 0x200.
- After the trap, mret -> redirect_pc=0x2000, MIE=1, MPIE=1. mret asserted during REDIRECT -> ignored.
- Same cycle exception_pending, mret and csr_we to mscratch=0xDEAD -> trap taken, mscratch unchanged.
- Write mcycle=0xFFFF_FFFF, mcycleh=0 -> next cycle reads mcycleh=1, mcycle=0; 10 retire pulses during IDLE -> minstret=10.
